// File: rtl/bram_ctrl_pkg.sv
// Shared types and constants for the UART-to-BRAM command sequencer.
package bram_ctrl_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_LAST = 4'hF;

  // Opcode field lives in the top two bits of a command byte.
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    RD_ISSUE,
    RD_WAIT,
    TX_WAIT,
    TX_SEND
  } state_e;

  function automatic logic [1:0] opcode_of(input logic [DATA_W-1:0] b);
    return b[7:6];
  endfunction

endpackage

// File: rtl/bram_uart_ctrl_if.sv
// Single-port block RAM bus shared by the command path and the LED scan.
interface bram_uart_ctrl_if;
  import bram_ctrl_pkg::*;

  logic              bram_ce;
  logic              bram_oce;
  logic              bram_reset;
  logic              bram_wre;
  logic [ADDR_W-1:0] bram_ad;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;

  // Controller side drives the port, memory side returns read data.
  modport master (
    output bram_ce, bram_oce, bram_reset, bram_wre, bram_ad, bram_din,
    input  bram_dout
  );

  modport slave (
    input  bram_ce, bram_oce, bram_reset, bram_wre, bram_ad, bram_din,
    output bram_dout
  );

endinterface

// File: rtl/bram_scan_req.sv
// Periodic LED scan requester: raises a read request every SCAN_INTERVAL
// cycles and walks the scan address once each requested word comes back.
module bram_scan_req
  import bram_ctrl_pkg::*;
#(
  parameter int SCAN_INTERVAL = 13500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grant_i,   // scan read placed on the bus next cycle
  input  logic              done_i,    // scan read data returned this cycle
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [23:0] CNT_LAST = 24'(SCAN_INTERVAL - 1);

  logic [23:0]       cnt_q;
  logic              pending_q;
  logic              busy_q;     // a granted scan read is still in the tag pipe
  logic [ADDR_W-1:0] addr_q;

  // Interval counter, pending flag, in-flight flag and scan address.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
    end else begin
      if (cnt_q == CNT_LAST) cnt_q <= '0;
      else                   cnt_q <= cnt_q + 24'd1;

      // A fresh interval tick wins over the completion of an older scan.
      if (cnt_q == CNT_LAST) pending_q <= 1'b1;
      else if (done_i)       pending_q <= 1'b0;

      if (grant_i)     busy_q <= 1'b1;
      else if (done_i) busy_q <= 1'b0;

      if (done_i) addr_q <= addr_q + 4'd1;
    end
  end

  assign req_o  = pending_q & ~busy_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/bram_uart_ctrl.sv
// Command sequencer and BRAM port arbiter: decodes UART command bytes into
// BRAM writes, single reads and 16-byte dumps, returns read data to the UART
// transmitter and interleaves periodic LED scan reads on idle bus cycles.
module bram_uart_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int READ_LATENCY  = 2,
  parameter int SCAN_INTERVAL = 13500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  input  logic              tx_busy_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_send_n_o,
  bram_uart_ctrl_if.master  bram_io,
  output logic [5:0]        led_data_o,
  output logic              overrun_o
);

  // FSM and transmit side
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              dump_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_send_n_q;
  logic              overrun_q;

  // Registered BRAM port
  logic              ce_q, oce_q, breset_q, wre_q;
  logic [ADDR_W-1:0] ad_q;
  logic [DATA_W-1:0] din_q;
  logic              rd_cur_q;    // the bus carries a read this cycle
  logic              rd_scan_q;   // ... and it belongs to the scan

  // Read tag pipe: one stage per cycle of BRAM read latency
  logic [READ_LATENCY-1:0] tag_v_q;
  logic [READ_LATENCY-1:0] tag_s_q;

  logic [5:0]        led_q;

  // Next-cycle command access and arbitration
  logic              cmd_wr_d;
  logic              cmd_rd_d;
  logic [ADDR_W-1:0] cmd_ad_d;
  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_grant;
  logic              scan_done;
  logic              cmd_done;

  // Decide which command access, if any, occupies the bus next cycle.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cmd_wr_d = 1'b0;
    cmd_rd_d = 1'b0;
    cmd_ad_d = addr_q;
    case (state_q)
      IDLE: begin
        if (rx_valid_i && rx_data_i[7]) begin
          cmd_rd_d = 1'b1;
          cmd_ad_d = (opcode_of(rx_data_i) == OP_DUMP) ? '0 : rx_data_i[3:0];
        end
      end
      WR_DATA: begin
        if (rx_valid_i) cmd_wr_d = 1'b1;
      end
      TX_SEND: begin
        if (dump_q && addr_q != ADDR_LAST) begin
          cmd_rd_d = 1'b1;
          cmd_ad_d = addr_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  // The command path always wins; the scan takes any cycle left free.
  assign scan_grant = scan_req & ~(cmd_wr_d | cmd_rd_d);
  assign scan_done  = tag_v_q[READ_LATENCY-1] &  tag_s_q[READ_LATENCY-1];
  assign cmd_done   = tag_v_q[READ_LATENCY-1] & ~tag_s_q[READ_LATENCY-1];

  bram_scan_req #(
    .SCAN_INTERVAL (SCAN_INTERVAL)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .grant_i (scan_grant),
    .done_i  (scan_done),
    .req_o   (scan_req),
    .addr_o  (scan_addr)
  );

  // Registered BRAM port: enables after reset, then command or scan access.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q      <= 1'b0;
      oce_q     <= 1'b0;
      breset_q  <= 1'b1;
      wre_q     <= 1'b0;
      ad_q      <= '0;
      din_q     <= '0;
      rd_cur_q  <= 1'b0;
      rd_scan_q <= 1'b0;
    end else begin
      ce_q      <= 1'b1;
      oce_q     <= 1'b1;
      breset_q  <= 1'b0;
      wre_q     <= cmd_wr_d;
      rd_cur_q  <= cmd_rd_d | scan_grant;
      rd_scan_q <= scan_grant;
      if (cmd_wr_d || cmd_rd_d) ad_q <= cmd_ad_d;
      else if (scan_grant)      ad_q <= scan_addr;
      if (cmd_wr_d) din_q <= rx_data_i;
    end
  end

  // Tag pipe tracking the owner of each read until its data appears.
  // NOTE: the tag pipe is control state and is cleared on reset, unlike the
  // BRAM contents, so no stale read can be routed after a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_q <= '0;
      tag_s_q <= '0;
    end else begin
      tag_v_q[0] <= rd_cur_q;
      tag_s_q[0] <= rd_scan_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_s_q[i] <= tag_s_q[i-1];
      end
    end
  end

  // LED register loads the low bits of each returned scan word.
  always_ff @(posedge clk) begin
    if (rst)            led_q <= '0;
    else if (scan_done) led_q <= bram_io.bram_dout[5:0];
  end

  // Command FSM with registered transmit outputs and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      dump_q      <= 1'b0;
      rd_q        <= '0;
      tx_data_q   <= '0;
      tx_send_n_q <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      tx_send_n_q <= 1'b1;
      if (rx_valid_i && (state_q inside {RD_ISSUE, RD_WAIT, TX_WAIT, TX_SEND}))
        overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (rx_valid_i) begin
            case (opcode_of(rx_data_i))
              OP_WRITE: begin
                addr_q  <= rx_data_i[3:0];
                state_q <= WR_DATA;
              end
              OP_READ: begin
                addr_q  <= rx_data_i[3:0];
                dump_q  <= 1'b0;
                state_q <= RD_ISSUE;
              end
              OP_DUMP: begin
                addr_q  <= '0;
                dump_q  <= 1'b1;
                state_q <= RD_ISSUE;
              end
              default: ;
            endcase
          end
        end
        WR_DATA: begin
          if (rx_valid_i) state_q <= IDLE;
        end
        RD_ISSUE: state_q <= RD_WAIT;
        RD_WAIT: begin
          if (cmd_done) begin
            rd_q <= bram_io.bram_dout;
            // Keep the byte on tx_data stable while the previous one is
            // still being shifted out; it is loaded in TX_WAIT instead.
            if (!tx_busy_i) tx_data_q <= bram_io.bram_dout;
            state_q <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (!tx_busy_i) begin
            tx_data_q <= rd_q;
            state_q   <= TX_SEND;
          end
        end
        TX_SEND: begin
          tx_send_n_q <= 1'b0;
          if (dump_q && addr_q != ADDR_LAST) begin
            addr_q  <= addr_q + 4'd1;
            state_q <= RD_ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bram_io.bram_ce    = ce_q;
  assign bram_io.bram_oce   = oce_q;
  assign bram_io.bram_reset = breset_q;
  assign bram_io.bram_wre   = wre_q;
  assign bram_io.bram_ad    = ad_q;
  assign bram_io.bram_din   = din_q;

  assign tx_data_o   = tx_data_q;
  assign tx_send_n_o = tx_send_n_q;
  assign led_data_o  = led_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_bram_uart_ctrl.sv
// Directed bench for bram_uart_ctrl with a 2-cycle BRAM model and a UART
// transmitter model that holds tx_busy for 20 cycles per byte.
module tb_bram_uart_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_send_n;
  logic [5:0] led_data;
  logic       overrun;

  bram_uart_ctrl_if bram_bus ();

  bram_uart_ctrl #(
    .READ_LATENCY  (2),
    .SCAN_INTERVAL (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .tx_busy_i   (tx_busy),
    .tx_data_o   (tx_data),
    .tx_send_n_o (tx_send_n),
    .bram_io     (bram_bus),
    .led_data_o  (led_data),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  // BRAM model: registered read plus output register (2-cycle latency).
  logic [7:0] mem [16] = '{default: 8'h00};
  logic [7:0] rd_stage = 8'h00;
  always @(posedge clk) begin
    if (bram_bus.bram_ce && bram_bus.bram_wre) mem[bram_bus.bram_ad] <= bram_bus.bram_din;
    if (bram_bus.bram_ce && !bram_bus.bram_wre) rd_stage <= mem[bram_bus.bram_ad];
    if (bram_bus.bram_reset)    bram_bus.bram_dout <= 8'h00;
    else if (bram_bus.bram_oce) bram_bus.bram_dout <= rd_stage;
  end

  // UART transmitter model and record of every transmitted byte.
  logic [7:0] sent [$];
  int         busy_cnt = 0;
  int         busy_viol = 0;
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else if (!tx_send_n) begin
      if (tx_busy) busy_viol++;
      sent.push_back(tx_data);
      busy_cnt = 20;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt != 0);
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic until_cyc(input int k);
    while (cyc < k) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_sends(input int n, input string tag);
    int k = 0;
    while (sent.size() < n && k < 3000) begin
      tick();
      k++;
    end
    check(tag, sent.size(), n);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (tx_busy && k < 200) begin
      tick();
      k++;
    end
    check("tx_idle", {31'd0, tx_busy}, 32'd0);
    repeat (4) tick();
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_send_n"}, {31'd0, tx_send_n}, 32'd1);
    check({p, "_tx_data"}, {24'd0, tx_data}, 32'h00);
    check({p, "_wre"}, {31'd0, bram_bus.bram_wre}, 32'd0);
    check({p, "_ad"}, {28'd0, bram_bus.bram_ad}, 32'd0);
    check({p, "_din"}, {24'd0, bram_bus.bram_din}, 32'h00);
    check({p, "_ce"}, {31'd0, bram_bus.bram_ce}, 32'd0);
    check({p, "_oce"}, {31'd0, bram_bus.bram_oce}, 32'd0);
    check({p, "_breset"}, {31'd0, bram_bus.bram_reset}, 32'd1);
    check({p, "_led"}, {26'd0, led_data}, 32'h00);
    check({p, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    int base;
    int n0;

    // Reset values, then enables come up one cycle after release.
    do_reset();
    check_reset_vals("rst0");
    tick();
    check("ce_up", {31'd0, bram_bus.bram_ce}, 32'd1);
    check("oce_up", {31'd0, bram_bus.bram_oce}, 32'd1);
    check("breset_down", {31'd0, bram_bus.bram_reset}, 32'd0);

    // WRITE 0xA5 to address 5, then READ it back.
    until_cyc(2);
    send_byte(8'h45);
    send_byte(8'hA5);                 // data byte in C3
    check("wr_wre", {31'd0, bram_bus.bram_wre}, 32'd1);
    check("wr_ad", {28'd0, bram_bus.bram_ad}, 32'd5);
    check("wr_din", {24'd0, bram_bus.bram_din}, 32'hA5);
    tick();
    check("wr_single", {31'd0, bram_bus.bram_wre}, 32'd0);
    send_byte(8'h85);                 // READ opcode in C5
    check("rd_issue_ad", {28'd0, bram_bus.bram_ad}, 32'd5);
    check("rd_issue_wre", {31'd0, bram_bus.bram_wre}, 32'd0);
    until_cyc(8);
    check("rd_data_early", {24'd0, tx_data}, 32'h00);
    until_cyc(9);
    check("rd_data", {24'd0, tx_data}, 32'hA5);
    until_cyc(10);
    check("send_n_c10", {31'd0, tx_send_n}, 32'd1);
    until_cyc(11);
    check("send_n_c11", {31'd0, tx_send_n}, 32'd0);
    until_cyc(12);
    check("send_n_c12", {31'd0, tx_send_n}, 32'd1);
    check("rd_one_pulse", sent.size(), 1);
    check("rd_sent", {24'd0, sent[0]}, 32'hA5);

    // Fill 0x10+i and dump all 16 words with a slow transmitter.
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h40 | 8'(i));
      send_byte(8'h10 + 8'(i));
    end
    wait_idle();
    base = sent.size();
    send_byte(8'hC0);
    wait_sends(base + 16, "dump_count");
    for (int i = 0; i < 16; i++)
      check($sformatf("dump_%0d", i), {24'd0, sent[base+i]}, 32'h10 + 32'(i));
    wait_idle();
    repeat (40) tick();
    check("dump_no_extra", sent.size(), base + 16);
    check("busy_respected", busy_viol, 0);

    // A byte arriving in TX_WAIT is dropped and sets the sticky overrun.
    base = sent.size();
    n0 = cyc;
    send_byte(8'h81);
    until_cyc(n0 + 7);
    send_byte(8'h82);
    until_cyc(n0 + 15);
    check("ovr_before", {31'd0, overrun}, 32'd0);
    send_byte(8'h47);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    wait_sends(base + 2, "ovr_count");
    check("ovr_rd1", {24'd0, sent[base]}, 32'h11);
    check("ovr_rd2", {24'd0, sent[base+1]}, 32'h12);
    wait_idle();
    send_byte(8'h84);
    wait_sends(base + 3, "ovr_next_count");
    check("ovr_next_rd", {24'd0, sent[base+2]}, 32'h14);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    wait_idle();

    // Reset during RD_WAIT of a DUMP discards the command.
    base = sent.size();
    send_byte(8'hC0);
    tick();                           // now in RD_WAIT
    rst = 1'b1;
    tick();
    check_reset_vals("rst_mid");
    do_reset();
    repeat (60) tick();
    check("rst_no_send", sent.size(), base);
    send_byte(8'h85);
    wait_sends(base + 1, "rst_after_count");
    check("rst_after_rd", {24'd0, sent[base]}, 32'h15);
    wait_idle();

    // Scan request collides with a READ issue: command first, scan next.
    base = sent.size();
    do_reset();
    until_cyc(8);
    send_byte(8'h83);
    check("conf_cmd_ad", {28'd0, bram_bus.bram_ad}, 32'd3);
    check("conf_cmd_wre", {31'd0, bram_bus.bram_wre}, 32'd0);
    tick();
    check("conf_scan_ad", {28'd0, bram_bus.bram_ad}, 32'd0);
    until_cyc(12);
    check("conf_tx_data", {24'd0, tx_data}, 32'h13);
    check("conf_led_early", {26'd0, led_data}, 32'h00);
    until_cyc(13);
    check("conf_led", {26'd0, led_data}, 32'h10);
    wait_sends(base + 1, "conf_count");
    check("conf_sent", {24'd0, sent[base]}, 32'h13);
    wait_idle();

    // LED scan walk over mem[k] = k | 0x40, including the wrap.
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h40 | 8'(i));
      send_byte(8'h40 | 8'(i));
    end
    repeat (4) tick();
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      until_cyc(16 + 8 * k);
      check($sformatf("led_%0d", k), {26'd0, led_data}, 32'(k % 16));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_uart_ctrl.md
# bram_uart_ctrl

Command sequencer and arbiter for the 16x8 single-port block RAM (`Gowin_SP`).
- Parses a byte command stream from the `uart` receiver and issues BRAM writes, single reads and 16-byte dumps.
- Returns read data through the `uart` transmitter.
- Shares the BRAM port with a periodic LED scan reader; the command path has priority.
- Sits in `top` between `uart` and `Gowin_SP`, and drives `led`.

## Interface
Parameters:
- READ_LATENCY, 2: cycles from a BRAM read issue to valid `bram_dout` (1 = bypass, 2 = output register with oce=1).
- SCAN_INTERVAL, 13500000: clk cycles between LED scan read requests.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data valid.
- tx_busy  in  1  UART transmitter busy.
- tx_data  out  8  byte to transmit; held stable until tx_busy falls.
- tx_send_n  out  1  active-low, one-cycle transmit start.
- bram_ce, bram_oce  out  1  BRAM clock/output enables.
- bram_reset  out  1  BRAM output reset.
- bram_wre  out  1  1 = write, 0 = read.
- bram_ad  out  4  BRAM address.
- bram_din  out  8  BRAM write data.
- bram_dout  in  8  BRAM read data.
- led_data  out  6  low 6 bits of the last scanned word.
- overrun  out  1  sticky; a byte was dropped.

## Operation
Command decode on the opcode byte:
- 01aa_aaaa = WRITE, address a[3:0]; the next byte is data.
- 10xx_aaaa = READ.
- 11xx_xxxx = DUMP addresses 0..15.
- 00xx_xxxx = ignored.

FSM states: IDLE, WR_DATA, RD_ISSUE, RD_WAIT, TX_WAIT, TX_SEND.
- IDLE: rx_valid with WRITE -> WR_DATA; READ or DUMP -> RD_ISSUE; else stay.
- WR_DATA: next rx_valid -> one-cycle write (bram_wre=1, bram_ad=addr, bram_din=byte) -> IDLE. A new opcode byte is not recognised here; every byte is data.
- RD_ISSUE: one-cycle read issue -> RD_WAIT.
- RD_WAIT: READ_LATENCY cycles, then capture bram_dout into tx_data -> TX_WAIT.
- TX_WAIT: tx_busy=0 -> TX_SEND.
- TX_SEND: tx_send_n=0 for one cycle. If DUMP and addr≠15, addr+1 -> RD_ISSUE; otherwise -> IDLE.
- rx_valid in RD_ISSUE, RD_WAIT, TX_WAIT or TX_SEND: byte dropped, overrun<=1.

Scan reader:
- A counter reaching SCAN_INTERVAL-1 wraps to 0 and sets scan_pending.
- Grant occurs in any cycle the FSM issues no BRAM access: one read of scan_addr, tagged as a scan read in a READ_LATENCY-deep tag pipe.
- On tag exit, led_data <= bram_dout[5:0]; scan_addr increments, 15 wraps to 0; scan_pending clears.
- The command path always wins a same-cycle conflict; the scan retries the next cycle. The scan never stalls commands.
- The tag pipe routes data by owner, so overlapping scan and command reads each capture their own word.

Arithmetic: addresses are 4-bit and wrap mod 16. The scan counter is 24-bit.

## Timing
- Reset values: tx_send_n=1, tx_data=0, bram_wre=0, bram_ad=0, bram_din=0, bram_ce=0, bram_oce=0, bram_reset=1, led_data=0, overrun=0, FSM=IDLE, scan counter=0, scan_addr=0, tag pipe empty.
- The cycle after rst falls: bram_ce=bram_oce=1 and bram_reset=0; these hold until the next reset.
- All outputs are registered.
- WRITE: data rx_valid in cycle N -> bram_wre=1 in N+1 only.
- READ: opcode rx_valid in N -> read issue in N+1 -> tx_data valid in N+2+READ_LATENCY. With tx_busy=0, tx_send_n=0 in N+4+READ_LATENCY.
- READ of an address written in the preceding command returns the new data. The write completes before any later issue.
- Reset mid-operation: the in-flight command, pending scan and tag pipe are discarded. No tx_send_n pulse follows reset.

## Structure
- Package `bram_ctrl_pkg`:
  - ADDR_W=4, DATA_W=8.
  - Opcode field constants OP_WRITE=2'b01, OP_READ=2'b10, OP_DUMP=2'b11.
  - FSM state enum.
- Sub-module `bram_scan_req`: interval counter, scan_pending, scan_addr; inputs grant and data-return; outputs req and addr.
- The arbiter, tag pipe and FSM stay in `bram_uart_ctrl`.

## Test plan
- Bytes 0x45, 0xA5 -> single write cycle ad=5, din=0xA5. Then 0x85 -> tx_data=0xA5 with one tx_send_n pulse at N+4+READ_LATENCY.
- Write 0x10+i to addresses 0..15, then 0xC0 -> 16 transmitted bytes 0x10..0x1F in order. Each send waits for tx_busy=0, with tx_busy held high for 20 cycles per byte.
- SCAN_INTERVAL=8, mem[k]=k|0x40 -> led_data cycles 0x00, 0x01 … 0x0F and wraps to 0x00 after address 15.
- Scan request in the same cycle as a READ issue -> command issues first; scan issues the next cycle; both capture the correct words.
- Byte arrives during TX_WAIT -> dropped, overrun=1 and it stays 1; next IDLE command works normally.
- rst asserted during RD_WAIT of a DUMP -> outputs at reset values next cycle; no further tx_send_n pulse; FSM in IDLE.
